rom_adr_sequencer: RTL and testbench

ROM_ADR_SEQUENCER -- requirements
Module: rom_adr_sequencer

---
 rtl/rom_adr_sequencer.sv | 134 +++++++++++++
 tb/tb_rom_adr_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_adr_sequencer.sv
// ROM address sequencer: 56-clock word cycle, serial address out (ia), serial instruction in (is).
// Optional macro ROM_RET_STACK_EN adds a one-level return register for jsb_req/ret_req.
module rom_adr_sequencer (
  input  logic       cph2,
  input  logic       pon,
  input  logic       halt,
  input  logic       br_req,
  input  logic       jsb_req,
  input  logic       ret_req,
  input  logic [7:0] br_adr,
  input  logic       is,
  output logic       sync,
  output logic       ia,
  output logic [7:0] pc,
  output logic [5:0] bit_t,
  output logic [9:0] inst,
  output logic       inst_vld,
  output logic [2:0] ack
);

  localparam logic [5:0] BIT_LAST     = 6'd55;
  localparam logic [5:0] ADR_FIRST    = 6'd19;
  localparam logic [5:0] CAPT_FIRST   = 6'd45;
  localparam logic [5:0] CAPT_LAST    = 6'd54;
  localparam logic [2:0] ACK_BR       = 3'b001;
  localparam logic [2:0] ACK_JSB      = 3'b010;
  localparam logic [2:0] ACK_RET      = 3'b100;

  logic [5:0] bitT_q, bitT_d;
  logic [7:0] pc_q, pc_d;
  logic [9:0] capture_q, capture_d;
  logic [9:0] inst_q, inst_d;
  logic       instVld_q, instVld_d;
  logic [2:0] ack_q, ack_d;
  logic       wordEnd;
  logic       iaBit;
  logic [7:0] pcInc;

`ifdef ROM_RET_STACK_EN
  logic [7:0] retR_q, retR_d;
`else
  logic       unusedRetReq;
  assign unusedRetReq = ret_req;
`endif

  assign wordEnd = (bitT_q == BIT_LAST);
  assign pcInc   = pc_q + 8'd1;

  // Address bits go out LSB first during bit times 19..26.
  always_comb begin
    iaBit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bitT_q == ADR_FIRST + 6'(k)) iaBit = pc_q[k];
    end
  end

  always_comb begin
    bitT_d    = wordEnd ? 6'd0 : bitT_q + 6'd1;
    capture_d = capture_q;
    for (int k = 0; k < 10; k++) begin
      if (bitT_q == CAPT_FIRST + 6'(k)) capture_d[k] = is;
    end
  end

  // Word boundary: publish the instruction and pick the next fetch address.
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    instVld_d = 1'b0;
    ack_d     = 3'b000;
`ifdef ROM_RET_STACK_EN
    retR_d    = retR_q;
`endif
    if (wordEnd) begin
      inst_d    = capture_q;
      instVld_d = 1'b1;
      if (halt) begin
        pc_d = pc_q;
`ifdef ROM_RET_STACK_EN
      end else if (ret_req) begin
        pc_d  = retR_q;
        ack_d = ACK_RET;
      end else if (jsb_req) begin
        retR_d = pcInc;
        pc_d   = br_adr;
        ack_d  = ACK_JSB;
`else
      end else if (jsb_req) begin
        pc_d  = br_adr;
        ack_d = ACK_JSB;
`endif
      end else if (br_req) begin
        pc_d  = br_adr;
        ack_d = ACK_BR;
      end else begin
        pc_d = pcInc;
      end
    end
  end

  always_ff @(posedge cph2 or negedge pon) begin
    if (!pon) begin
      bitT_q    <= 6'd0;
      pc_q      <= 8'd0;
      capture_q <= 10'd0;
      inst_q    <= 10'd0;
      instVld_q <= 1'b0;
      ack_q     <= 3'b000;
    end else begin
      bitT_q    <= bitT_d;
      pc_q      <= pc_d;
      capture_q <= capture_d;
      inst_q    <= inst_d;
      instVld_q <= instVld_d;
      ack_q     <= ack_d;
    end
  end

`ifdef ROM_RET_STACK_EN
  always_ff @(posedge cph2 or negedge pon) begin
    if (!pon) retR_q <= 8'd0;
    else      retR_q <= retR_d;
  end
`endif

  assign sync     = (bitT_q >= CAPT_FIRST) && (bitT_q <= CAPT_LAST);
  assign ia       = iaBit;
  assign pc       = pc_q;
  assign bit_t    = bitT_q;
  assign inst     = inst_q;
  assign inst_vld = instVld_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_rom_adr_sequencer.sv
// Self-checking bench for rom_adr_sequencer: word-level model checked every cycle plus literal checks.
// Follows ROM_RET_STACK_EN the same way the design does.
module tb_rom_adr_sequencer;

  logic       cph2 = 1'b0;
  logic       pon = 1'b0;
  logic       halt = 1'b0, br_req = 1'b0, jsb_req = 1'b0, ret_req = 1'b0;
  logic [7:0] br_adr = 8'd0;
  logic       is = 1'b0;
  logic       sync, ia, inst_vld;
  logic [7:0] pc;
  logic [5:0] bit_t;
  logic [9:0] inst;
  logic [2:0] ack;

  int nTests = 0;
  int nFail  = 0;

`ifdef ROM_RET_STACK_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  rom_adr_sequencer dut (
    .cph2(cph2), .pon(pon), .halt(halt), .br_req(br_req), .jsb_req(jsb_req),
    .ret_req(ret_req), .br_adr(br_adr), .is(is), .sync(sync), .ia(ia), .pc(pc),
    .bit_t(bit_t), .inst(inst), .inst_vld(inst_vld), .ack(ack)
  );

  always #5 cph2 = ~cph2;

  // Reference model in word-level terms: position in the word, fetch address, return slot.
  int         mBit = 0;
  int         mPc  = 0;
  int         mRet = 0;
  logic [9:0] mCap = '0;
  int         mInst = 0;
  int         mVld = 0;
  int         mAck = 0;

  always @(posedge cph2 or negedge pon) begin
    if (!pon) begin
      mBit <= 0; mPc <= 0; mRet <= 0; mCap <= '0; mInst <= 0; mVld <= 0; mAck <= 0;
    end else begin
      mVld <= 0;
      mAck <= 0;
      if (mBit >= 45 && mBit <= 54) mCap[mBit-45] <= is;
      if (mBit == 55) begin
        mInst <= int'(mCap);
        mVld  <= 1;
        if (halt) begin
          mPc <= mPc;
        end else if (RET_EN && ret_req) begin
          mPc <= mRet; mAck <= 4;
        end else if (jsb_req) begin
          if (RET_EN) mRet <= (mPc + 1) % 256;
          mPc <= br_adr; mAck <= 2;
        end else if (br_req) begin
          mPc <= br_adr; mAck <= 1;
        end else begin
          mPc <= (mPc + 1) % 256;
        end
      end
      mBit <= (mBit + 1) % 56;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, the DUT must match the model.
  always @(negedge cph2) begin
    int expIa;
    expIa = (mBit >= 19 && mBit <= 26) ? ((mPc >> (mBit - 19)) & 1) : 0;
    checkOutput("model bit_t", int'(bit_t), mBit);
    checkOutput("model sync", int'(sync), (mBit >= 45 && mBit <= 54) ? 1 : 0);
    checkOutput("model ia", int'(ia), expIa);
    checkOutput("model pc", int'(pc), mPc);
    checkOutput("model inst", int'(inst), mInst);
    checkOutput("model inst_vld", int'(inst_vld), mVld);
    checkOutput("model ack", int'(ack), mAck);
  end

  task automatic applyStimulus(input logic h, input logic br, input logic jsb,
                               input logic ret, input logic [7:0] adr);
    halt = h; br_req = br; jsb_req = jsb; ret_req = ret; br_adr = adr;
  endtask

  task automatic waitBit(input int n);
    for (int i = 0; i < 60; i++) begin
      @(posedge cph2); #1;
      if (mBit == n) return;
    end
    nTests++;
    nFail++;
    $display("[TB] FAIL wait for bit %0d: not reached, required within 60 cycles", n);
  endtask

  task automatic checkAll(input string tag, input int expPc, input int expAck);
    checkOutput({tag, " pc"}, int'(pc), expPc);
    checkOutput({tag, " ack"}, int'(ack), expAck);
  endtask

  initial begin
    logic [9:0] pat;
    pat = 10'b10_0100_0011;
    applyStimulus(0, 0, 0, 0, 8'h00);
    is = 0;
    repeat (3) @(posedge cph2);
    #1;
    checkOutput("reset bit_t", int'(bit_t), 0);
    checkOutput("reset pc", int'(pc), 0);
    checkOutput("reset sync", int'(sync), 0);
    checkOutput("reset inst", int'(inst), 0);
    checkOutput("reset ack", int'(ack), 0);
    pon = 1;
    @(posedge cph2); #1;
    checkOutput("first bit_t", int'(bit_t), 1);
    checkOutput("first pc", int'(pc), 0);

    waitBit(45);
    checkOutput("sync at 45", int'(sync), 1);
    waitBit(55);
    checkOutput("sync at 55", int'(sync), 0);
    for (int w = 0; w < 254; w++) waitBit(0);
    waitBit(0);
    checkAll("pc before wrap", 8'hFF, 0);
    waitBit(0);
    checkAll("pc after wrap", 8'h00, 0);

    applyStimulus(0, 1, 0, 0, 8'h12);
    waitBit(0);
    checkAll("br to 12", 8'h12, 3'b001);
    applyStimulus(0, 0, 0, 0, 8'h00);

    // Instruction word with a stray status pulse at bit 11.
    for (int i = 0; i < 56; i++) begin
      if (mBit >= 45 && mBit <= 54) is = pat[mBit-45];
      else is = (mBit == 11);
      @(posedge cph2); #1;
    end
    is = 0;
    checkOutput("inst captured", int'(inst), 10'h243);
    checkOutput("inst_vld strobe", int'(inst_vld), 1);
    @(posedge cph2); #1;
    checkOutput("inst_vld single", int'(inst_vld), 0);

    applyStimulus(0, 1, 0, 0, 8'h30);
    waitBit(0);
    checkAll("br to 30", 8'h30, 3'b001);
    applyStimulus(0, 1, 1, 0, 8'h80);
    waitBit(0);
    checkAll("jsb beats br", 8'h80, 3'b010);
    applyStimulus(0, 1, 0, 0, 8'h80);
    waitBit(0);
    checkAll("br after jsb", 8'h80, 3'b001);

    if (RET_EN) begin
      applyStimulus(1, 0, 0, 1, 8'h00);
      waitBit(0);
      checkAll("halt blocks ret", 8'h80, 0);
      applyStimulus(0, 0, 0, 1, 8'h00);
      waitBit(0);
      checkAll("ret to 31", 8'h31, 3'b100);
    end else begin
      applyStimulus(1, 1, 0, 0, 8'h55);
      waitBit(0);
      checkAll("halt blocks br", 8'h80, 0);
      applyStimulus(0, 0, 0, 1, 8'h00);
      waitBit(0);
      checkAll("ret ignored", 8'h81, 0);
    end

    applyStimulus(0, 1, 0, 0, 8'hFF);
    waitBit(0);
    checkAll("br to FF", 8'hFF, 3'b001);
    applyStimulus(0, 0, 1, 0, 8'h40);
    waitBit(0);
    checkAll("jsb at FF", 8'h40, 3'b010);
    if (RET_EN) begin
      applyStimulus(0, 0, 0, 1, 8'h00);
      waitBit(0);
      checkAll("ret wraps to 00", 8'h00, 3'b100);
    end else begin
      applyStimulus(0, 0, 0, 0, 8'h00);
      waitBit(0);
      checkAll("inc after jsb", 8'h41, 0);
    end

    // Mid-word reset with a partial capture and a pending branch.
    applyStimulus(0, 0, 0, 0, 8'h00);
    waitBit(45);
    is = 1;
    waitBit(50);
    applyStimulus(0, 1, 0, 0, 8'h77);
    pon = 0;
    #1;
    checkOutput("midreset bit_t", int'(bit_t), 0);
    checkOutput("midreset pc", int'(pc), 0);
    checkOutput("midreset sync", int'(sync), 0);
    checkOutput("midreset ia", int'(ia), 0);
    checkOutput("midreset inst", int'(inst), 0);
    checkOutput("midreset inst_vld", int'(inst_vld), 0);
    checkOutput("midreset ack", int'(ack), 0);
    is = 0;
    applyStimulus(0, 0, 0, 0, 8'h00);
    repeat (2) @(posedge cph2);
    #1;
    pon = 1;
    @(posedge cph2); #1;
    checkOutput("post reset bit_t", int'(bit_t), 1);
    checkOutput("post reset pc", int'(pc), 0);
    waitBit(0);
    checkAll("post reset word", 8'h01, 0);
    checkOutput("post reset inst", int'(inst), 0);
    repeat (3) @(posedge cph2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
